// File: rtl/fpu_pkg.sv
// Shared types and constants for the fpu issue/retire control slice.
package fpu_pkg;

  typedef enum logic [2:0] {FPU_ADD = 3'd0, FPU_SUB = 3'd1, FPU_MUL = 3'd2, FPU_DIV = 3'd3} fpu_op_e;
  typedef enum logic [1:0] {RM_NE = 2'd0, RM_Z = 2'd1, RM_PINF = 2'd2, RM_NINF = 2'd3} rmode_e;

  // Bit order matches the core's flag bus: {inf,snan,qnan,ine,overflow,zero,div_by_zero}
  typedef struct packed {
    logic inf;
    logic snan;
    logic qnan;
    logic ine;
    logic overflow;
    logic zero;
    logic div_by_zero;
  } fpu_flags_t;

  localparam logic [31:0] FPU_QNAN = 32'h7FC0_0000;

  function automatic logic op_legal(input logic [2:0] op);
    return !op[2];
  endfunction

endpackage

// File: rtl/fpu_res_fifo.sv
// Circular result buffer; pointers carry an extra wrap bit so full/empty fall out of the difference.
module fpu_res_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [AW:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [W-1:0] mem_q [DEPTH];
  logic         do_push, do_pop;

  assign count   = wptr_q - rptr_q;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wptr_d = wptr_q + (AW+1)'(do_push);
    rptr_d = rptr_q + (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  // Head reads zero when empty so downstream never sees stale contents.
  assign rdata = empty ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/retire wrapper around a fixed-latency fpu core: registers ops in, tracks them
// through a valid/tag pipe, and banks results in a credit-protected FIFO.
module fpu_issue_ctrl
  import fpu_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int RES_DEPTH = 8,
  parameter int TAG_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [1:0]        req_rmode,
  input  logic [31:0]       req_opa,
  input  logic [31:0]       req_opb,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [31:0]       fpu_opa,
  output logic [31:0]       fpu_opb,
  output logic [2:0]        fpu_op,
  output logic [1:0]        fpu_rmode,
  input  logic [31:0]       fpu_out,
  input  logic [6:0]        fpu_flags,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [31:0]       res_data,
  output logic [6:0]        res_flags,
  output logic [TAG_W-1:0]  res_tag,
  output logic              res_illegal
);

  localparam int CW = $clog2(RES_DEPTH) + 1;

  typedef struct packed {
    logic [31:0]      data;
    fpu_flags_t       flags;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } res_t;

  logic [31:0] fpu_opa_q, fpu_opa_d, fpu_opb_q, fpu_opb_d;
  logic [2:0]  fpu_op_q, fpu_op_d;
  logic [1:0]  fpu_rmode_q, fpu_rmode_d;

  logic [LATENCY-1:0]            vld_pipe_q, vld_pipe_d;
  logic [LATENCY-1:0]            ill_pipe_q, ill_pipe_d;
  logic [LATENCY-1:0][TAG_W-1:0] tag_pipe_q, tag_pipe_d;
  logic [CW-1:0]                 inflight_q, inflight_d;

  logic          issue, capture;
  logic [CW:0]   credits_used;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  res_t          wr_entry, head;
  fpu_flags_t    qnan_flags;

  assign issue   = req_valid && req_ready;
  assign capture = vld_pipe_q[LATENCY-1];

  // Credits count everything not yet popped, so a result always has a slot when it lands.
  assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign req_ready    = !rst && !fifo_full && (credits_used < (CW+1)'(RES_DEPTH));

  always_comb begin
    fpu_opa_d   = fpu_opa_q;
    fpu_opb_d   = fpu_opb_q;
    fpu_op_d    = fpu_op_q;
    fpu_rmode_d = fpu_rmode_q;
    if (issue) begin
      fpu_opa_d   = req_opa;
      fpu_opb_d   = req_opb;
      fpu_op_d    = op_legal(req_op) ? req_op : FPU_ADD;
      fpu_rmode_d = req_rmode;
    end
    vld_pipe_d = {vld_pipe_q[LATENCY-2:0], issue};
    ill_pipe_d = {ill_pipe_q[LATENCY-2:0], !op_legal(req_op)};
    tag_pipe_d = {tag_pipe_q[LATENCY-2:0], req_tag};
    inflight_d = inflight_q;
    case ({issue, capture})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fpu_opa_q   <= '0;
      fpu_opb_q   <= '0;
      fpu_op_q    <= '0;
      fpu_rmode_q <= '0;
      vld_pipe_q  <= '0;
      ill_pipe_q  <= '0;
      tag_pipe_q  <= '0;
      inflight_q  <= '0;
    end else begin
      fpu_opa_q   <= fpu_opa_d;
      fpu_opb_q   <= fpu_opb_d;
      fpu_op_q    <= fpu_op_d;
      fpu_rmode_q <= fpu_rmode_d;
      vld_pipe_q  <= vld_pipe_d;
      ill_pipe_q  <= ill_pipe_d;
      tag_pipe_q  <= tag_pipe_d;
      inflight_q  <= inflight_d;
    end
  end

  assign fpu_opa   = fpu_opa_q;
  assign fpu_opb   = fpu_opb_q;
  assign fpu_op    = fpu_op_q;
  assign fpu_rmode = fpu_rmode_q;

  always_comb begin
    qnan_flags      = '0;
    qnan_flags.qnan = 1'b1;
    wr_entry.tag     = tag_pipe_q[LATENCY-1];
    wr_entry.illegal = ill_pipe_q[LATENCY-1];
    if (ill_pipe_q[LATENCY-1]) begin
      wr_entry.data  = FPU_QNAN;
      wr_entry.flags = qnan_flags;
    end else begin
      wr_entry.data  = fpu_out;
      wr_entry.flags = fpu_flags;
    end
  end

  fpu_res_fifo #(.DEPTH(RES_DEPTH), .W($bits(res_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (capture),
    .wdata (wr_entry),
    .pop   (res_ready),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign res_valid   = !fifo_empty;
  assign res_data    = head.data;
  assign res_flags   = head.flags;
  assign res_tag     = head.tag;
  assign res_illegal = head.illegal;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: stand-in fpu core, queue-based scoreboard, directed and random traffic.
module tb_fpu_issue_ctrl;

  localparam int L  = 4;
  localparam int D  = 8;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready;
  logic [2:0]    req_op;
  logic [1:0]    req_rmode;
  logic [31:0]   req_opa, req_opb;
  logic [TW-1:0] req_tag;
  logic [31:0]   fpu_opa, fpu_opb, fpu_out;
  logic [2:0]    fpu_op;
  logic [1:0]    fpu_rmode;
  logic [6:0]    fpu_flags;
  logic          res_valid, res_ready;
  logic [31:0]   res_data;
  logic [6:0]    res_flags;
  logic [TW-1:0] res_tag;
  logic          res_illegal;

  int checks = 0;
  int errors = 0;

  fpu_issue_ctrl #(.LATENCY(L), .RES_DEPTH(D), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_rmode(req_rmode),
    .req_opa(req_opa), .req_opb(req_opb), .req_tag(req_tag),
    .fpu_opa(fpu_opa), .fpu_opb(fpu_opb), .fpu_op(fpu_op), .fpu_rmode(fpu_rmode),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_flags(res_flags), .res_tag(res_tag), .res_illegal(res_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stand-in core: exact answers for the directed vectors, a scrambling function otherwise.
  function automatic logic [38:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op, input logic [1:0] rm);
    logic [31:0] h;
    if (a == 32'h4060_0000 && b == 32'h4060_0000 && rm == 2'd0) begin
      case (op)
        3'd0: return {32'h40E0_0000, 7'h00};
        3'd1: return {32'h0000_0000, 7'h02};
        3'd2: return {32'h4144_0000, 7'h00};
        default: return {32'h3F80_0000, 7'h00};
      endcase
    end
    if (a == 32'h3F80_0000 && b == 32'h0 && op == 3'd3) return {32'h7F80_0000, 7'h41};
    h = (a ^ {b[15:0], b[31:16]}) + {29'd0, op} + {22'd0, rm, 8'd0};
    return {h, h[6:0] ^ b[13:7]};
  endfunction

  logic [38:0] fs [0:L-2];
  always @(posedge clk) begin
    fs[0] <= core_fn(fpu_opa, fpu_opb, fpu_op, fpu_rmode);
    for (int i = 1; i <= L - 2; i++) fs[i] <= fs[i-1];
  end
  assign {fpu_out, fpu_flags} = fs[L-2];

  // Scoreboard: every accepted, not-yet-popped op, stamped with the edge it was accepted on.
  typedef struct {
    logic [31:0]   d;
    logic [6:0]    f;
    logic [TW-1:0] tag;
    logic          ill;
    int            t;
  } exp_t;

  exp_t        q[$];
  int          now = 0;
  logic [31:0] last_opa = '0, last_opb = '0;
  logic [2:0]  last_op = '0;
  logic [1:0]  last_rm = '0;

  always @(negedge clk) begin
    logic exp_rdy, exp_vld;
    exp_t e;
    if (rst) begin
      q.delete();
      last_opa = '0; last_opb = '0; last_op = '0; last_rm = '0;
    end
    exp_rdy = !rst && (q.size() < D);
    exp_vld = (q.size() > 0) && (now >= q[0].t + L);
    chk("req_ready", req_ready, exp_rdy);
    chk("res_valid", res_valid, exp_vld);
    chk("res_data",    res_data,    exp_vld ? q[0].d   : 32'h0);
    chk("res_flags",   res_flags,   exp_vld ? q[0].f   : 7'h0);
    chk("res_tag",     res_tag,     exp_vld ? q[0].tag : 4'h0);
    chk("res_illegal", res_illegal, exp_vld ? q[0].ill : 1'b0);
    chk("fpu_opa", fpu_opa, last_opa);
    chk("fpu_opb", fpu_opb, last_opb);
    chk("fpu_op", fpu_op, last_op);
    chk("fpu_rmode", fpu_rmode, last_rm);
    chk("push_when_full", dut.u_fifo.push && dut.u_fifo.full, 1'b0);
    if (!rst) begin
      if (res_valid && res_ready && q.size() > 0) void'(q.pop_front());
      if (req_valid && req_ready) begin
        last_opa = req_opa; last_opb = req_opb; last_rm = req_rmode;
        last_op  = req_op[2] ? 3'd0 : req_op;
        e.tag = req_tag;
        e.ill = req_op[2];
        e.t   = now + 1;
        if (req_op[2]) {e.d, e.f} = {32'h7FC0_0000, 7'h10};
        else           {e.d, e.f} = core_fn(req_opa, req_opb, req_op, req_rmode);
        q.push_back(e);
      end
    end
    now++;
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [1:0] rm, input logic [31:0] a,
                       input logic [31:0] b, input logic [TW-1:0] tag);
    req_valid = 1'b1; req_op = op; req_rmode = rm; req_opa = a; req_opb = b; req_tag = tag;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        step();
        req_valid = 1'b0;
        return;
      end
      step();
    end
    chk("issue_timeout", 32'd1, 32'd0);
    req_valid = 1'b0;
  endtask

  task automatic wait_res(input string name, input logic [31:0] d, input logic [6:0] f,
                          input logic [TW-1:0] tag, input logic ill);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (res_valid) begin
        chk({name, "_data"}, res_data, d);
        chk({name, "_flags"}, res_flags, f);
        chk({name, "_tag"}, res_tag, tag);
        chk({name, "_illegal"}, res_illegal, ill);
        step();
        return;
      end
      step();
    end
    chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    int acc;
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_rmode = '0;
    req_opa = '0; req_opb = '0; req_tag = '0; res_ready = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    repeat (2) step();
    rst = 1'b0;

    // single add: visible exactly LATENCY edges after the handshake edge
    res_ready = 1'b1;
    issue(3'd0, 2'd0, 32'h4060_0000, 32'h4060_0000, 4'd3);
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      chk("t1_res_valid_timing", res_valid, (k == L));
      if (k == L) begin
        chk("t1_data", res_data, 32'h40E0_0000);
        chk("t1_flags", res_flags, 7'h00);
        chk("t1_tag", res_tag, 4'd3);
      end
    end
    step();

    // back-to-back mul/div, then divide by zero
    issue(3'd2, 2'd0, 32'h4060_0000, 32'h4060_0000, 4'd5);
    issue(3'd3, 2'd0, 32'h4060_0000, 32'h4060_0000, 4'd6);
    wait_res("t2_mul", 32'h4144_0000, 7'h00, 4'd5, 1'b0);
    wait_res("t2_div", 32'h3F80_0000, 7'h00, 4'd6, 1'b0);
    issue(3'd3, 2'd0, 32'h3F80_0000, 32'h0000_0000, 4'd7);
    wait_res("t3_dbz", 32'h7F80_0000, 7'h41, 4'd7, 1'b0);

    // credit limit with a stalled consumer
    res_ready = 1'b0;
    acc = 0;
    req_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      req_op = 3'($urandom_range(0, 3)); req_rmode = 2'($urandom);
      req_opa = $urandom; req_opb = $urandom; req_tag = 4'(c);
      @(negedge clk);
      if (req_ready) acc++;
      step();
    end
    req_valid = 1'b0;
    chk("t4_accepted", 32'(acc), 32'd8);
    @(negedge clk);
    chk("t4_ready_low", req_ready, 1'b0);
    step();
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_ready_same_cycle", req_ready, 1'b0);
    step();
    res_ready = 1'b0;
    @(negedge clk);
    chk("t4_ready_next_cycle", req_ready, 1'b1);
    step();
    res_ready = 1'b1;
    repeat (12) step();

    // illegal op sandwiched between legal adds
    issue(3'd0, 2'd0, 32'h4060_0000, 32'h4060_0000, 4'd1);
    issue(3'd5, 2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd2);
    issue(3'd0, 2'd0, 32'h4060_0000, 32'h4060_0000, 4'd3);
    wait_res("t5_a", 32'h40E0_0000, 7'h00, 4'd1, 1'b0);
    wait_res("t5_ill", 32'h7FC0_0000, 7'h10, 4'd2, 1'b1);
    wait_res("t5_b", 32'h40E0_0000, 7'h00, 4'd3, 1'b0);

    // reset with 2 buffered and 3 in flight
    res_ready = 1'b0;
    issue(3'd0, 2'd0, 32'h4060_0000, 32'h4060_0000, 4'd8);
    issue(3'd2, 2'd0, 32'h4060_0000, 32'h4060_0000, 4'd9);
    repeat (L + 2) step();
    issue(3'd1, 2'd0, 32'h1111_1111, 32'h2222_2222, 4'd10);
    issue(3'd2, 2'd0, 32'h3333_3333, 32'h4444_4444, 4'd11);
    issue(3'd3, 2'd0, 32'h5555_5555, 32'h6666_6666, 4'd12);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_res_valid", res_valid, 1'b0);
    chk("t6_rst_req_ready", req_ready, 1'b0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_post_res_valid", res_valid, 1'b0);
    chk("t6_post_req_ready", req_ready, 1'b1);
    step();
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_no_stale", res_valid, 1'b0);
      step();
    end

    // random traffic against the scoreboard
    for (int c = 0; c < 2000; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      req_op    = 3'($urandom);
      req_rmode = 2'($urandom);
      req_opa   = $urandom;
      req_opb   = $urandom;
      req_tag   = 4'($urandom);
      res_ready = (c % 200 < 40) ? 1'b0 : ($urandom_range(0, 9) < 6);
      step();
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    repeat (30) step();
    @(negedge clk);
    chk("final_drained", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
